// File: rtl/apb_bridge_n.sv
// apb_bridge_n: AHB-lite slave to APB4 master bridge for NUM_SLV peripherals.
// Handles PREADY wait states, PSLVERR and decode-miss errors, a PREADY
// timeout, and PSTRB generation. Each accepted transfer goes through the
// states SETUP -> ACCESS. Error responses use the two-cycle sequence ERR1 -> ERR2.
`timescale 1ns/1ps

module apb_bridge_n #(
  parameter int                 NUM_SLV = 8,
  parameter int                 SLV_AW  = 12,
  parameter int                 ADDR_W  = 40,
  parameter logic [NUM_SLV-1:0] SLV_EN  = {NUM_SLV{1'b1}},
  parameter int                 TIMEOUT = 255
) (
  input  logic                  hclk,
  input  logic                  hrst_b,
  input  logic                  hsel,
  input  logic [ADDR_W-1:0]     haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [31:0]           hrdata,
  output logic [ADDR_W-1:0]     paddr,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  output logic [NUM_SLV-1:0]    psel,
  output logic                  penable,
  input  logic [NUM_SLV*32-1:0] prdata,
  input  logic [NUM_SLV-1:0]    pready,
  input  logic [NUM_SLV-1:0]    pslverr
);

  localparam int          IDX_W      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      to_cnt;

  logic [IDX_W-1:0] req_idx;
  logic             req_hit;
  logic             accept;
  logic             sel_ready;
  logic             sel_err;
  logic [31:0]      sel_rdata;

  // htrans[0] (SEQ vs NONSEQ) does not change how the bridge behaves.
  logic unused_htrans;
  assign unused_htrans = htrans[0];

  assign req_idx = haddr[SLV_AW+IDX_W-1:SLV_AW];
  assign accept  = hsel & htrans[1] & hready & ((state == S_IDLE) | (state == S_ERR2));

  // Byte lanes covered by an AHB access of the given size and alignment.
  function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'd0:    strb_of = 4'b0001 << lsb;
      3'd1:    strb_of = 4'b0011 << {lsb[1], 1'b0};
      default: strb_of = 4'b1111;
    endcase
  endfunction

  // Decode the requested slot. Also mux the response lines of the slot that is active.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    req_hit   = 1'b0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (req_idx == IDX_W'(k)) req_hit = SLV_EN[k];
      if (idx_q == IDX_W'(k)) begin
        sel_ready = pready[k];
        sel_err   = pslverr[k];
        sel_rdata = prdata[k*32 +: 32];
      end
    end
  end

  // Write data passes straight through while the APB transfer is live.
  assign pwdata = ((state == S_SETUP) || (state == S_ACCESS)) ? hwdata : '0;

  // Bridge FSM. Every output here is loaded with the value it will have in the next state.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      to_cnt    <= '0;
      hreadyout <= 1'b1;
      hresp     <= RESP_OKAY;
      hrdata    <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pstrb     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          if (accept && req_hit) begin
            state     <= S_SETUP;
            idx_q     <= req_idx;
            to_cnt    <= '0;
            hreadyout <= 1'b0;
            hresp     <= RESP_OKAY;
            paddr     <= haddr;
            pwrite    <= hwrite;
            pstrb     <= hwrite ? strb_of(hsize, haddr[1:0]) : 4'b0000;
            psel      <= NUM_SLV'(1) << req_idx;
            penable   <= 1'b0;
          end else if (accept) begin
            state     <= S_ERR1;
            hreadyout <= 1'b0;
            hresp     <= RESP_ERROR;
          end else begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= RESP_OKAY;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
        end
        S_ACCESS: begin
          if (sel_ready) begin
            psel    <= '0;
            penable <= 1'b0;
            if (sel_err) begin
              state  <= S_ERR1;
              hresp  <= RESP_ERROR;
              hrdata <= '0;
            end else begin
              state     <= S_IDLE;
              hreadyout <= 1'b1;
              if (!pwrite) hrdata <= sel_rdata;
            end
          end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= S_ERR1;
            hresp   <= RESP_ERROR;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp     <= RESP_ERROR;
        end
        default: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= RESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_n.sv
// tb_apb_bridge_n: the AHB driver pushes the expected response of each
// accepted transfer, and a negedge monitor pops and compares it on completion.
// APB slaves respond with a programmable number of wait states and an optional error.
`timescale 1ns/1ps

module tb_apb_bridge_n;

  localparam int         NUM_SLV = 8;
  localparam int         SLV_AW  = 12;
  localparam int         ADDR_W  = 40;
  localparam int         TIMEOUT = 4;
  localparam logic [7:0] SLV_EN  = 8'hEF;   // slot 4 disabled

  logic                  hclk = 1'b0;
  logic                  hrst_b;
  logic                  hsel;
  logic [ADDR_W-1:0]     haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [31:0]           hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [31:0]           hrdata;
  logic [ADDR_W-1:0]     paddr;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic [NUM_SLV-1:0]    psel;
  logic                  penable;
  logic [NUM_SLV*32-1:0] prdata;
  logic [NUM_SLV-1:0]    pready;
  logic [NUM_SLV-1:0]    pslverr;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  apb_bridge_n #(
    .NUM_SLV(NUM_SLV), .SLV_AW(SLV_AW), .ADDR_W(ADDR_W),
    .SLV_EN(SLV_EN), .TIMEOUT(TIMEOUT)
  ) dut (
    .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .psel(psel),
    .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
    int          setups;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec  = 0;
  int n_fail = 0;

  // APB expectations for the transfer currently in its data phase.
  logic [7:0]        cur_psel   = '0;
  logic [ADDR_W-1:0] cur_paddr  = '0;
  logic              cur_pwrite = 1'b0;
  logic [3:0]        cur_pstrb  = '0;
  logic [31:0]       cur_pwdata = '0;
  logic [31:0]       cur_rdata  = '0;
  logic              cur_err    = 1'b0;
  int                cur_idx    = 0;
  int                cur_wait   = 0;

  // Reference model state, owned by the driver.
  logic [31:0] m_rdata  = '0;
  int          m_setups = 0;
  int          m_busy   = 0;

  // Observed counts, owned by the monitor.
  int setup_cnt = 0;
  int busy_cnt  = 0;
  int mon_waits = 0;
  bit in_data   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte lanes: an aligned group of 1, 2 or 4 bytes containing the address.
  function automatic logic [3:0] lanes(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
    int nb;
    int base;
    nb   = (sz >= 3'd2) ? 4 : (1 << sz);
    base = (int'(a[1:0]) / nb) * nb;
    return 4'(((1 << nb) - 1) << base);
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      hsel   = 1'($urandom);
      htrans = 2'($urandom_range(0, 1));
      haddr  = {8'($urandom), $urandom};
      @(posedge hclk); #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first data-phase cycle.
  task automatic do_xfer(input logic [ADDR_W-1:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] wd, input int wt, input logic er,
                         input logic [31:0] rd);
    exp_t e;
    int   bound;
    int   idx;
    int   acc;
    bit   hit;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    bound  = 0;
    while (!hreadyout && bound < 100) begin
      @(posedge hclk); #1;
      bound++;
    end
    if (!hreadyout) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_wait: hreadyout still low after %0d cycles, expected high", bound);
      return;
    end
    @(posedge hclk); #1;
    idx = int'(a[SLV_AW +: 3]);
    hit = SLV_EN[idx];
    if (hit) begin
      acc = (wt + 1 > TIMEOUT) ? TIMEOUT : wt + 1;
      m_setups++;
      m_busy += 1 + acc;
      if (wt + 1 > TIMEOUT) begin
        e.resp  = 2'b01;
        e.waits = 1 + acc + 1;
      end else if (er) begin
        e.resp  = 2'b01;
        e.waits = 1 + acc + 1;
        m_rdata = '0;
      end else begin
        e.resp  = 2'b00;
        e.waits = 1 + acc;
        if (!w) m_rdata = rd;
      end
    end else begin
      e.resp  = 2'b01;
      e.waits = 1;
    end
    e.rdata  = m_rdata;
    e.setups = m_setups;
    e.busy   = m_busy;
    exp_q.push_back(e);
    cur_psel   = hit ? 8'(1 << idx) : 8'h00;
    cur_paddr  = a;
    cur_pwrite = w;
    cur_pstrb  = w ? lanes(a, sz) : 4'b0000;
    cur_pwdata = wd;
    cur_idx    = idx;
    cur_wait   = wt;
    cur_err    = er;
    cur_rdata  = rd;
    hwdata     = wd;
    hsel       = 1'($urandom);
    htrans     = 2'b00;
    haddr      = {8'($urandom), $urandom};
  endtask

  // APB slaves: unselected slots are driven with noise, and the active slot follows cur_*.
  initial begin
    int acc;
    acc     = 0;
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    forever begin
      @(posedge hclk); #1;
      if (psel != '0 && penable) acc++;
      else acc = 0;
      pready  = 8'($urandom);
      pslverr = 8'($urandom);
      for (int k = 0; k < NUM_SLV; k++) prdata[k*32 +: 32] = $urandom;
      if (penable) begin
        pready[cur_idx]           = (acc > cur_wait);
        pslverr[cur_idx]          = cur_err;
        prdata[cur_idx*32 +: 32]  = cur_rdata;
      end
    end
  end

  // Monitor: APB-side checks, then AHB completion scoreboard.
  always @(negedge hclk) begin
    if (!hrst_b) begin
      in_data   = 1'b0;
      setup_cnt = 0;
      busy_cnt  = 0;
      exp_q.delete();
    end else begin
      if (psel != '0) begin
        busy_cnt++;
        if (!penable) setup_cnt++;
        check("psel",   64'(psel),   64'(cur_psel));
        check("paddr",  64'(paddr),  64'(cur_paddr));
        check("pwrite", 64'(pwrite), 64'(cur_pwrite));
        check("pstrb",  64'(pstrb),  64'(cur_pstrb));
        check("pwdata", 64'(pwdata), 64'(cur_pwdata));
      end else begin
        check("pwdata_idle", 64'(pwdata), 64'(0));
      end
      if (in_data) begin
        if (!hreadyout) begin
          mon_waits++;
        end else begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_completion: completion seen, expected none pending");
          end else begin
            mon_e = exp_q.pop_front();
            check("hresp",      64'(hresp),     64'(mon_e.resp));
            check("wait_states", 64'(mon_waits), 64'(mon_e.waits));
            check("hrdata",     64'(hrdata),    64'(mon_e.rdata));
            check("apb_setups", 64'(setup_cnt), 64'(mon_e.setups));
            check("apb_cycles", 64'(busy_cnt),  64'(mon_e.busy));
          end
          in_data = 1'b0;
        end
      end else begin
        check("idle_hreadyout", 64'(hreadyout), 64'(1));
        check("idle_hresp",     64'(hresp),     64'(0));
      end
      if (hsel && htrans[1] && hready) begin
        in_data   = 1'b1;
        mon_waits = 0;
      end
    end
  end

  initial begin
    int bound;
    logic [ADDR_W-1:0] ra;
    logic [2:0]        rsz;
    logic              rw;
    logic              rer;
    int                rwt;

    hrst_b = 1'b0;
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = '0;
    repeat (3) @(posedge hclk);
    #2;
    check("rst_hreadyout", 64'(hreadyout), 64'(1));
    check("rst_hresp",     64'(hresp),     64'(0));
    check("rst_hrdata",    64'(hrdata),    64'(0));
    check("rst_paddr",     64'(paddr),     64'(0));
    check("rst_pwrite",    64'(pwrite),    64'(0));
    check("rst_pstrb",     64'(pstrb),     64'(0));
    check("rst_psel",      64'(psel),      64'(0));
    check("rst_penable",   64'(penable),   64'(0));
    hrst_b = 1'b1;
    @(posedge hclk); #1;

    // Directed transfers, issued back to back.
    do_xfer(40'h2004, 1'b0, 3'd2, $urandom,     0,    1'b0, 32'hDEADBEEF);
    do_xfer(40'h5003, 1'b1, 3'd0, 32'hAB000000, 0,    1'b0, $urandom);
    do_xfer(40'h1000, 1'b0, 3'd2, $urandom,     3,    1'b0, 32'h12345678);
    do_xfer(40'h3000, 1'b1, 3'd2, $urandom,     0,    1'b1, $urandom);
    do_xfer(40'h9000, 1'b0, 3'd2, $urandom,     0,    1'b0, 32'hCAFEF00D);
    do_xfer(40'h4000, 1'b0, 3'd2, $urandom,     0,    1'b0, $urandom);
    do_xfer(40'h7008, 1'b0, 3'd2, $urandom,     0,    1'b0, 32'h0BADCAFE);
    do_xfer(40'h2010, 1'b0, 3'd2, $urandom,     1000, 1'b0, $urandom);
    do_xfer(40'h6002, 1'b1, 3'd1, $urandom,     1,    1'b0, $urandom);
    do_xfer(40'h3001, 1'b0, 3'd2, $urandom,     2,    1'b1, $urandom);
    idle_cycles(3);

    // Reset in the middle of ACCESS.
    do_xfer(40'h3010, 1'b0, 3'd2, $urandom, 1000, 1'b0, $urandom);
    @(posedge hclk); #3;
    check("rst_mid_penable_before", 64'(penable), 64'(1));
    hrst_b = 1'b0;
    #1;
    check("rst_mid_psel",      64'(psel),      64'(0));
    check("rst_mid_penable",   64'(penable),   64'(0));
    check("rst_mid_hreadyout", 64'(hreadyout), 64'(1));
    check("rst_mid_hresp",     64'(hresp),     64'(0));
    check("rst_mid_hrdata",    64'(hrdata),    64'(0));
    m_rdata  = '0;
    m_setups = 0;
    m_busy   = 0;
    @(posedge hclk); #2;
    hrst_b = 1'b1;
    @(posedge hclk); #1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      ra  = {8'($urandom), $urandom};
      rsz = 3'($urandom_range(0, 3));
      rw  = 1'($urandom);
      rer = ($urandom_range(0, 5) == 0);
      rwt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      do_xfer(ra, rw, rsz, $urandom, rwt, rer, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);

    bound = 0;
    while ((exp_q.size() != 0 || in_data) && bound < 200) begin
      @(posedge hclk); #1;
      bound++;
    end
    if (exp_q.size() != 0 || in_data) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
